// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with shadowed, boundary-aligned config updates.
// Optional per-channel period counters are enabled with CLK_DIV_GEN_PERIOD_CNT_EN.
module clk_div_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DEF_DIV  = 50,
  parameter int unsigned LOCK_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_high,
  input  logic [DIV_W-1:0]    cfg_phase,
  input  logic                sync_start,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [NUM_CH-1:0]   clkout,
  output logic [NUM_CH-1:0]   tick,
  output logic                locked
`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] period_cnt
`endif
);

  localparam int unsigned LockW = $clog2(LOCK_CYC + 1);

  typedef enum logic {StIdle, StRun} ch_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
    logic [DIV_W-1:0] phase;
  } ch_cfg_t;

  localparam ch_cfg_t CfgRst = '{
    div:   DIV_W'(DEF_DIV),
    high:  DIV_W'(DEF_DIV / 2),
    phase: '0
  };

  // Clamped values guarantee the output always toggles.
  function automatic ch_cfg_t clamp_cfg(input ch_cfg_t c);
    ch_cfg_t r;
    r.div   = (c.div < DIV_W'(2)) ? DIV_W'(2) : c.div;
    r.high  = (c.high == '0) ? DIV_W'(1) :
              ((c.high >= r.div) ? r.div - DIV_W'(1) : c.high);
    r.phase = (c.phase >= r.div) ? '0 : c.phase;
    return r;
  endfunction

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  ch_cfg_t          act_q   [NUM_CH];
  ch_cfg_t          act_d   [NUM_CH];
  ch_cfg_t          shd_q   [NUM_CH];
  ch_cfg_t          shd_d   [NUM_CH];
  ch_cfg_t          shd_clamp [NUM_CH];

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clkout_q, clkout_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] last;
  logic [LockW-1:0]  lock_q, lock_d;
  logic              cfg_ok;

  assign cfg_ok = cfg_we && (32'(cfg_ch) < NUM_CH);

  always_comb begin
    clkout_d = '0;
    tick_d   = '0;
    pend_d   = pend_q;
    apply    = '0;
    wr       = '0;
    last     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      act_d[i]     = act_q[i];
      shd_d[i]     = shd_q[i];
      shd_clamp[i] = clamp_cfg(shd_q[i]);
      wr[i]        = cfg_ok && (cfg_ch == 4'(i));
      last[i]      = (cnt_q[i] == act_q[i].div - DIV_W'(1));

      case (state_q[i])
        StIdle: begin
          apply[i] = pend_q[i];
          cnt_d[i] = '0;
          if (ch_en[i]) begin
            state_d[i] = StRun;
            cnt_d[i]   = pend_q[i] ? shd_clamp[i].phase : act_q[i].phase;
          end
        end
        StRun: begin
          if (!ch_en[i]) begin
            // Stop at once; no attempt to finish the current period.
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            clkout_d[i] = (cnt_q[i] < act_q[i].high);
            tick_d[i]   = last[i];
            if (sync_start) begin
              apply[i] = pend_q[i];
              cnt_d[i] = pend_q[i] ? shd_clamp[i].phase : act_q[i].phase;
            end else if (last[i]) begin
              apply[i] = pend_q[i];
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase

      if (apply[i]) begin
        act_d[i]  = shd_clamp[i];
        pend_d[i] = 1'b0;
      end
      // A same-cycle write lands in the shadow after any apply above.
      if (wr[i]) begin
        shd_d[i]  = '{div: cfg_div, high: cfg_high, phase: cfg_phase};
        pend_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (cfg_ok || sync_start) begin
      lock_d = '0;
    end else if (lock_q != LockW'(LOCK_CYC)) begin
      lock_d = lock_q + LockW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q   <= '0;
      pend_q   <= '0;
      clkout_q <= '0;
      tick_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        act_q[i]   <= CfgRst;
        shd_q[i]   <= CfgRst;
      end
    end else begin
      lock_q   <= lock_d;
      pend_q   <= pend_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        act_q[i]   <= act_d[i];
        shd_q[i]   <= shd_d[i];
      end
    end
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign locked = (lock_q == LockW'(LOCK_CYC));

`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
  logic [15:0] pcnt_q [NUM_CH];
  logic [15:0] pcnt_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pcnt_d[i] = pcnt_q[i];
      if (sync_start) begin
        pcnt_d[i] = '0;
      end else if (tick_q[i]) begin
        pcnt_d[i] = pcnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt_q[i] <= pcnt_d[i];
      end
    end
  end

  always_comb begin
    period_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      period_cnt[i*16 +: 16] = pcnt_q[i];
    end
  end
`else
  // No period counters in this build.
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_clk_div_gen;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [15:0] cfg_high;
  logic [15:0] cfg_phase;
  logic        sync_start;
  logic [3:0]  ch_en;
  logic [3:0]  clkout;
  logic [3:0]  tick;
  logic        locked;
`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
  logic [63:0] period_cnt;
`endif

  clk_div_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .sync_start (sync_start),
    .ch_en      (ch_en),
    .clkout     (clkout),
    .tick       (tick),
    .locked     (locked)
`ifdef CLK_DIV_GEN_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  // kind: 0 = clkout bit, 1 = tick bit, 2 = locked
  typedef struct packed {
    int   cyc;
    int   kind;
    int   ch;
    logic val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc;
  int    checks;
  int    errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int kind, input int ch, input logic v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    e.val  = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_wave(input int ch, input int start, input int div, input int high,
                             input int cnt0, input int n, input string nm);
    for (int j = 0; j < n; j++) begin
      int c;
      c = (cnt0 + j) % div;
      push(start + j, 0, ch, (c < high), {nm, "_clk"});
      push(start + j, 1, ch, (c == div - 1), {nm, "_tick"});
    end
  endtask

  task automatic expect_all_zero(input int c, input string nm);
    for (int k = 0; k < 4; k++) begin
      push(c, 0, k, 1'b0, {nm, "_clk"});
      push(c, 1, k, 1'b0, {nm, "_tick"});
    end
    push(c, 2, 0, 1'b0, {nm, "_lock"});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int ch, input int d, input int h, input int p);
    cfg_we    = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_div   = 16'(d);
    cfg_high  = 16'(h);
    cfg_phase = 16'(p);
  endtask

  // Monitor: compare every expectation due this cycle; stale ones are failures.
  always @(negedge clk) begin : mon
    int   k;
    logic act;
    k = 0;
    while (k < exp_q.size()) begin
      if (exp_q[k].cyc == cyc) begin
        case (exp_q[k].kind)
          0:       act = clkout[exp_q[k].ch];
          1:       act = tick[exp_q[k].ch];
          default: act = locked;
        endcase
        checks = checks + 1;
        if (act !== exp_q[k].val) begin
          errors = errors + 1;
          $display("FAIL %s ch%0d cyc=%0d got=%b want=%b", name_q[k], exp_q[k].ch, cyc, act,
                   exp_q[k].val);
        end
        exp_q.delete(k);
        name_q.delete(k);
      end else if (exp_q[k].cyc < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s stale cyc=%0d got=unchecked want=checked at %0d", name_q[k], cyc,
                 exp_q[k].cyc);
        exp_q.delete(k);
        name_q.delete(k);
      end else begin
        k = k + 1;
      end
    end
  end

  int r0, d1, s, c0, c1, v, x;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    cfg_high = '0;
    cfg_phase = '0;
    sync_start = 1'b0;
    ch_en = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, then ch0 on defaults (50/25) and lock after 64 cycles.
    r0 = cyc;
    expect_all_zero(r0, "reset");
    rst = 1'b0;
    ch_en = 4'b0001;
    expect_wave(0, r0 + 2, 50, 25, 0, 120, "ch0_def");
    push(r0 + 10, 0, 1, 1'b0, "idle1_clk");
    push(r0 + 10, 0, 3, 1'b0, "idle3_clk");
    push(r0 + 63, 2, 0, 1'b0, "lock_pre");
    push(r0 + 64, 2, 0, 1'b1, "lock_rise");

    // ch1: div 10, high 3.
    wait_until(r0 + 130);
    d1 = cyc;
    set_cfg(1, 10, 3, 0);
    expect_wave(1, d1 + 3, 10, 3, 0, 80, "ch1_d10");
    expect_wave(1, d1 + 83, 4, 2, 0, 40, "ch1_d4");
    push(d1 + 1, 2, 0, 1'b0, "lock_drop1");
    push(d1 + 64, 2, 0, 1'b0, "lock_wait1");
    push(d1 + 65, 2, 0, 1'b1, "lock_back1");
    push(d1 + 76, 2, 0, 1'b0, "lock_drop2");
    push(d1 + 139, 2, 0, 1'b0, "lock_wait2");
    push(d1 + 140, 2, 0, 1'b1, "lock_back2");
    wait_until(d1 + 1);
    cfg_we = 1'b0;
    ch_en = 4'b0011;

    // Reprogram ch1 to div 4 / high 2 while its cnt is 3.
    wait_until(d1 + 75);
    set_cfg(1, 4, 2, 0);
    wait_until(d1 + 76);
    cfg_we = 1'b0;

    // ch2 / ch3 in antiphase after sync_start.
    wait_until(d1 + 150);
    s = cyc;
    set_cfg(2, 10, 5, 5);
    wait_until(s + 1);
    set_cfg(3, 10, 5, 0);
    wait_until(s + 2);
    cfg_we = 1'b0;
    ch_en = 4'b1111;
    wait_until(s + 5);
    sync_start = 1'b1;
    expect_wave(2, s + 7, 10, 5, 5, 40, "ch2_sync");
    expect_wave(3, s + 7, 10, 5, 0, 40, "ch3_sync");
    push(s + 6, 2, 0, 1'b0, "lock_sync");
    wait_until(s + 6);
    sync_start = 1'b0;

    // Clamp: div 1 / high 0 -> period 2, high 1.
    wait_until(s + 60);
    c0 = cyc;
    ch_en = 4'b1101;
    push(c0 + 1, 0, 1, 1'b0, "ch1_stop_clk");
    push(c0 + 1, 1, 1, 1'b0, "ch1_stop_tick");
    wait_until(c0 + 2);
    set_cfg(1, 1, 0, 0);
    wait_until(c0 + 3);
    cfg_we = 1'b0;
    ch_en = 4'b1111;
    expect_wave(1, c0 + 5, 2, 1, 0, 130, "clamp_d1");

    // Clamp: div 6 / high 9 / phase 8 -> high 5, phase 0.
    wait_until(c0 + 30);
    c1 = cyc;
    ch_en = 4'b0111;
    wait_until(c1 + 1);
    set_cfg(3, 6, 9, 8);
    wait_until(c1 + 2);
    cfg_we = 1'b0;
    ch_en = 4'b1111;
    expect_wave(3, c1 + 4, 6, 5, 0, 100, "clamp_d6");

    // Out-of-range channel write is ignored and leaves locked high.
    wait_until(c1 + 80);
    v = cyc;
    set_cfg(7, 3, 1, 0);
    push(v + 1, 2, 0, 1'b1, "badch_lock1");
    push(v + 2, 2, 0, 1'b1, "badch_lock2");
    push(v + 10, 2, 0, 1'b1, "badch_lock3");
    wait_until(v + 1);
    cfg_we = 1'b0;

    // Reset with a pending write on ch2; afterwards ch2 must run on defaults.
    wait_until(v + 30);
    x = cyc;
    set_cfg(2, 20, 10, 0);
    wait_until(x + 1);
    cfg_we = 1'b0;
    ch_en = 4'b0000;
    rst = 1'b1;
    expect_all_zero(x + 1, "rst_mid");
    expect_all_zero(x + 2, "rst_hold");
    wait_until(x + 4);
    rst = 1'b0;
    ch_en = 4'b0100;
    expect_wave(2, x + 6, 50, 25, 0, 60, "ch2_post_rst");
    push(x + 67, 2, 0, 1'b0, "lock_pre_rst");
    push(x + 68, 2, 0, 1'b1, "lock_rise_rst");

    wait_until(x + 140);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
      errors = errors + exp_q.size();
      checks = checks + exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised multi-channel clock generator; successor to the fixed four-output PLL test block.
- Derives NUM_CH divided clocks from one reference clock in fabric logic.
- Each channel has a runtime-programmable divide ratio, high time (duty) and phase offset; channels are phase-aligned by a common sync pulse.
- Lock indicator mirrors PLL-style "locked". Sits between the board oscillator and downstream peripheral logic.

Parameters:
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 16, width of the divide, high-time and phase fields
- DEF_DIV, 50, reset divide ratio for all channels
- LOCK_CYC, 64, quiet cycles required before locked asserts

Ports:
- clk  in  1  reference clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  4  target channel index
- cfg_div  in  DIV_W  divide ratio
- cfg_high  in  DIV_W  high-time in clk cycles
- cfg_phase  in  DIV_W  start count loaded on enable/sync
- sync_start  in  1  realign all enabled channels
- ch_en  in  NUM_CH  per-channel run enable
- clkout  out  NUM_CH  divided clock levels (registered)
- tick  out  NUM_CH  one-cycle pulse on last cycle of each period
- locked  out  1  configuration stable, outputs valid

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - cnt = 0, clkout = 0, tick = 0, locked = 0, all pending flags clear.
  - Active and shadow regs: div = DEF_DIV, high = DEF_DIV/2, phase = 0.
- Per-channel states: IDLE (ch_en = 0) and RUN.
- IDLE:
  - cnt held at 0; clkout and tick forced 0 on the next cycle.
  - A pending shadow is copied to the active regs immediately.
- IDLE -> RUN on ch_en[i] = 1:
  - The next cycle loads cnt = phase.
  - cnt then increments by 1 each cycle and wraps from div-1 to 0.
- Outputs, 1-cycle registered latency from cnt:
  - clkout[i] = (cnt < high).
  - tick[i] = (cnt == div-1).
- Clamping, applied when a value is copied into the active regs:
  - div < 2 -> 2.
  - high = 0 -> 1.
  - high >= div -> div-1.
  - phase >= div -> 0.
  - Result: output always toggles; never stuck.
- Config writes:
  - cfg_we writes the shadow regs of channel cfg_ch and sets its pending flag.
  - cfg_ch >= NUM_CH is ignored.
  - A later write before the update replaces the shadow (last write wins).
- Glitch-free update:
  - In RUN, the shadow is copied at the first period boundary (cnt == div-1) strictly after the write cycle.
  - A write in the boundary cycle waits one full period.
  - At the boundary, cnt restarts at 0, not at phase.
- sync_start:
  - All RUN channels apply any pending shadow and load cnt = phase on the next cycle.
  - Takes priority over a simultaneous boundary or enable edge.
  - A cfg_we in the same cycle goes to the shadow only.
- ch_en falling mid-period: the channel stops immediately; there is no period completion.
- locked:
  - A lock counter clears on reset release, any accepted cfg_we, or sync_start.
  - It increments each cycle and saturates at LOCK_CYC.
  - locked = 1 while the counter equals LOCK_CYC.
  - ch_en changes do not affect locked.
- Reset asserted mid-operation returns every channel to its reset values asynchronously; pending writes are lost.

Optional Feature:
- Macro CLK_DIV_GEN_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt, NUM_CH*16 bits.
  - One 16-bit wrapping counter per channel increments on each tick; reset to 0.
  - Cleared by sync_start.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset, then ch_en = 4'b0001 with defaults -> clkout[0] period 50 clk, high 25, low 25; one tick per 50 cycles; locked rises 64 cycles after reset release.
- Write ch1: div = 10, high = 3, phase = 0; enable ch1 -> clkout[1] high 3, low 7, repeating; tick[1] every 10 cycles.
- Write ch2: div = 10, high = 5, phase = 5; write ch3: div = 10, high = 5, phase = 0; enable both, pulse sync_start -> clkout[2] is the inverse of clkout[3] from the cycle after sync onward.
- Ch1 running at div 10; write div = 4, high = 2 at cnt = 3 -> old period completes; new period-4 waveform starts at cnt 0 with no runt pulse; locked drops and recovers after 64 cycles.
- Clamp cases: div = 1, high = 0 -> period 2, high 1. div = 6, high = 9, phase = 8 -> high 5, phase 0. cfg_ch = 7 with NUM_CH = 4 -> no state change, locked unaffected.
- Assert rst while all channels run and a write is pending -> all outputs 0 immediately; after release, defaults restored and the pending value is discarded.
